// File: rtl/mac_feeder_pkg.sv
// Shared definitions for the MAC operand feeder.
//   feeder_state_e : sequencer states
//   STALL_CNT_W    : width of the optional stall counter output
//   depth_is_pow2  : FIFO depth legality check (power of two, at least 2)
package mac_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } feeder_state_e;

    localparam int STALL_CNT_W = 16;

    function automatic bit depth_is_pow2(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with count-based full/empty.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   wr_valid/data  : write request; accepted when wr_ready
//   wr_ready       : not full (independent of a same-cycle pop)
//   rd_pop         : consume the head entry (ignored when empty)
//   rd_data        : current head, visible combinationally
//   empty          : no entries stored
module sync_fifo
    import mac_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty
);
    localparam bit DEPTH_OK = depth_is_pow2(DEPTH);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    generate
        if (!DEPTH_OK) begin : g_bad_depth
            $error("sync_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  push;
    logic                  pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign wr_ready = !full;
    assign push     = wr_valid && !full;
    assign pop      = rd_pop && !empty;
    assign rd_data  = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/mac_operand_feeder.sv
// Operand feeder for the MAC accumulator: buffers A/B operand streams and
// sequences one dot-product of `len` pairs per `start`.
// Optional feature macro: MAC_FEEDER_STALL_CNT_EN (builds the stall counter;
// otherwise stall_cnt is tied to 0).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   a_wr_*, b_wr_*           : operand FIFO write interfaces (ready = not full)
//   start, len               : job request, sampled only in IDLE
//   busy, done               : not-IDLE flag, one-cycle completion pulse
//   mac_en, mac_clr          : MAC En / Clr
//   mac_a, mac_b             : MAC Ain / Bin, zero when mac_en is low
//   stall_cnt                : RUN cycles lost to an empty FIFO
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | one-cycle mac_clr pulse
// RUN   | issue a pair whenever both FIFO heads are present
// DRAIN | one cycle for the MAC product register to land
// DONE  | done pulse, Cout is final
module mac_operand_feeder
    import mac_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int LEN_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_wr_valid,
    input  logic [DATA_WIDTH-1:0]  a_wr_data,
    output logic                   a_wr_ready,
    input  logic                   b_wr_valid,
    input  logic [DATA_WIDTH-1:0]  b_wr_data,
    output logic                   b_wr_ready,
    input  logic                   start,
    input  logic [LEN_W-1:0]       len,
    output logic                   busy,
    output logic                   done,
    output logic                   mac_en,
    output logic                   mac_clr,
    output logic [DATA_WIDTH-1:0]  mac_a,
    output logic [DATA_WIDTH-1:0]  mac_b,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    feeder_state_e         state;
    feeder_state_e         state_nxt;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      issue_cnt;
    logic [DATA_WIDTH-1:0] a_head;
    logic [DATA_WIDTH-1:0] b_head;
    logic                  a_empty;
    logic                  b_empty;
    logic                  pair_ok;
    logic                  last_pair;
    logic                  job_start;

    sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (a_wr_valid),
        .wr_data  (a_wr_data),
        .wr_ready (a_wr_ready),
        .rd_pop   (mac_en),
        .rd_data  (a_head),
        .empty    (a_empty)
    );

    sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (b_wr_valid),
        .wr_data  (b_wr_data),
        .wr_ready (b_wr_ready),
        .rd_pop   (mac_en),
        .rd_data  (b_head),
        .empty    (b_empty)
    );

    assign pair_ok   = !a_empty && !b_empty;
    assign job_start = (state == ST_IDLE) && start;
    // Widened compare so len = 2**LEN_W-1 cannot wrap.
    assign last_pair = ({1'b0, issue_cnt} + (LEN_W+1)'(1)) == {1'b0, len_q};

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        mac_en    = 1'b0;
        mac_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                mac_clr   = 1'b1;
                state_nxt = (len_q != '0) ? ST_RUN : ST_DRAIN;
            end
            ST_RUN: begin
                if (pair_ok) begin
                    mac_en = 1'b1;
                    if (last_pair) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: state_nxt = ST_DONE;
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign mac_a = mac_en ? a_head : '0;
    assign mac_b = mac_en ? b_head : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            issue_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (job_start) begin
                len_q     <= len;
                issue_cnt <= '0;
            end else if (mac_en) begin
                issue_cnt <= issue_cnt + LEN_W'(1);
            end
        end
    end

`ifdef MAC_FEEDER_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q;

    // Cleared as the job enters CLEAR; saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (job_start) begin
            stall_q <= '0;
        end else if ((state == ST_RUN) && !mac_en && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_operand_feeder.sv
module tb_mac_operand_feeder;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int LW    = 8;

    logic          clk;
    logic          rst;
    logic          a_wr_valid, b_wr_valid;
    logic [DW-1:0] a_wr_data, b_wr_data;
    logic          a_wr_ready, b_wr_ready;
    logic          start;
    logic [LW-1:0] len;
    logic          busy, done, mac_en, mac_clr;
    logic [DW-1:0] mac_a, mac_b;
    logic [15:0]   stall_cnt;

    mac_operand_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LEN_W(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_wr_valid (a_wr_valid),
        .a_wr_data  (a_wr_data),
        .a_wr_ready (a_wr_ready),
        .b_wr_valid (b_wr_valid),
        .b_wr_data  (b_wr_data),
        .b_wr_ready (b_wr_ready),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .mac_en     (mac_en),
        .mac_clr    (mac_clr),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MAC_FEEDER_STALL_CNT_EN
    localparam int EXP_STALLS = 2;
`else
    localparam int EXP_STALLS = 0;
`endif

    typedef struct {
        int n;
        int a[4];
        int b[4];
        int len;
        int exp_sum;
        int exp_en;
        int exp_lat;
    } vec_t;

    vec_t vecs[4];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference MAC: Cout as the accumulator would hold it, plus event log.
    int sum, en_cnt, clr_cnt, done_cnt, last_en, clr_at;
    int en_a[$];
    int en_b[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        if (mac_clr) begin
            sum = 0;
            clr_cnt++;
            clr_at = cyc;
        end
        if (mac_en) begin
            sum += int'(mac_a) * int'(mac_b);
            en_cnt++;
            last_en = cyc;
            en_a.push_back(int'(mac_a));
            en_b.push_back(int'(mac_b));
        end
        if (done) done_cnt++;
        total++;
        if (mac_en && mac_clr) begin
            bad++;
            $display("FAIL en_clr_overlap: mac_en=%0b mac_clr=%0b (cycle %0d)", mac_en, mac_clr, cyc);
        end
        total++;
        if (!mac_en && (mac_a != '0 || mac_b != '0)) begin
            bad++;
            $display("FAIL idle_operands: mac_a=%0d mac_b=%0d expected 0 (cycle %0d)", mac_a, mac_b, cyc);
        end
    endtask

    // Outputs sampled at the falling edge; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic clear_mon();
        sum = 0; en_cnt = 0; clr_cnt = 0; done_cnt = 0; last_en = -1; clr_at = -1;
        en_a.delete();
        en_b.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_wr_valid = 1'b0; b_wr_valid = 1'b0; a_wr_data = '0; b_wr_data = '0;
        start = 1'b0; len = '0;
        tick();
        tick();
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic preload_pair(input int a, input int b);
        a_wr_valid = 1'b1; a_wr_data = DW'(a);
        b_wr_valid = 1'b1; b_wr_data = DW'(b);
        tick();
        a_wr_valid = 1'b0; b_wr_valid = 1'b0;
    endtask

    task automatic start_job(input int l, output int s);
        start = 1'b1; len = LW'(l); s = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                at = cyc;
                break;
            end
            tick();
        end
        if (at < 0) begin
            total++; bad++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end else begin
            tick();
        end
    endtask

    function automatic int q_at(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    initial begin
        int s, at, s2, stall_seen;

        vecs[0] = '{4, '{1, 2, 3, 4},         '{5, 6, 7, 8},         4, 70,     4, 7};
        vecs[1] = '{0, '{0, 0, 0, 0},         '{0, 0, 0, 0},         0, 0,      0, 3};
        vecs[2] = '{2, '{255, 255, 0, 0},     '{255, 255, 0, 0},     2, 130050, 2, 5};
        vecs[3] = '{3, '{7, 0, 9, 0},         '{2, 5, 1, 0},         3, 23,     3, 6};

        clear_mon();
        do_reset();
        check("rst_busy",     busy,       0);
        check("rst_done",     done,       0);
        check("rst_mac_en",   mac_en,     0);
        check("rst_mac_clr",  mac_clr,    0);
        check("rst_mac_a",    mac_a,      0);
        check("rst_mac_b",    mac_b,      0);
        check("rst_stall",    stall_cnt,  0);
        check("rst_a_ready",  a_wr_ready, 1);
        check("rst_b_ready",  b_wr_ready, 1);

        // Table-driven best-case jobs with pre-filled FIFOs.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            for (int i = 0; i < vecs[v].n; i++) preload_pair(vecs[v].a[i], vecs[v].b[i]);
            start_job(vecs[v].len, s);
            wait_done(40, at);
            check($sformatf("v%0d_latency", v), at - s,   vecs[v].exp_lat);
            check($sformatf("v%0d_cout", v),    sum,      vecs[v].exp_sum);
            check($sformatf("v%0d_en_cnt", v),  en_cnt,   vecs[v].exp_en);
            check($sformatf("v%0d_clr_cnt", v), clr_cnt,  1);
            check($sformatf("v%0d_clr_at", v),  clr_at,   s + 1);
            check($sformatf("v%0d_done_cnt", v), done_cnt, 1);
            check($sformatf("v%0d_stall", v),   stall_cnt, 0);
            check($sformatf("v%0d_busy_end", v), busy,    0);
            if (vecs[v].exp_en > 0) begin
                check($sformatf("v%0d_done_gap", v), at - last_en, 2);
                check($sformatf("v%0d_first_a", v), q_at(en_a, 0), vecs[v].a[0]);
                check($sformatf("v%0d_last_b", v),  q_at(en_b, vecs[v].exp_en - 1),
                      vecs[v].b[vecs[v].exp_en - 1]);
            end
        end

        // len=0 leaves pre-filled FIFOs untouched for the following job.
        do_reset();
        preload_pair(10, 3);
        preload_pair(20, 4);
        start_job(0, s);
        wait_done(20, at);
        check("len0_latency", at - s, 3);
        check("len0_en_cnt",  en_cnt, 0);
        check("len0_cout",    sum,    0);
        clear_mon();
        start_job(2, s);
        wait_done(20, at);
        check("after_len0_cout",    sum,             110);
        check("after_len0_first_a", q_at(en_a, 0),   10);
        check("after_len0_latency", at - s,          5);

        // Starved job: A written every cycle, B every other cycle.
        do_reset();
        start = 1'b1; len = LW'(3); s = cyc;
        tick();
        start = 1'b0;
        at = -1; stall_seen = -1;
        for (int k = 1; k <= 20; k++) begin
            a_wr_valid = (k <= 3);
            a_wr_data  = DW'(k);
            b_wr_valid = (k == 1 || k == 3 || k == 5);
            b_wr_data  = DW'(3 + (k + 1) / 2);
            if (done && at < 0) begin
                at = cyc;
                stall_seen = int'(stall_cnt);
            end
            tick();
        end
        a_wr_valid = 1'b0; b_wr_valid = 1'b0;
        check("stall_latency", at - s,        8);
        check("stall_cnt",     stall_seen,    EXP_STALLS);
        check("stall_cout",    sum,           32);
        check("stall_en_cnt",  en_cnt,        3);
        check("stall_b1",      q_at(en_b, 1), 5);
        check("stall_a2",      q_at(en_a, 2), 3);

        // Back-to-back jobs; a start in the done cycle must be ignored.
        clear_mon();
        preload_pair(1, 2);
        preload_pair(3, 4);
        preload_pair(5, 6);
        preload_pair(7, 8);
        start_job(2, s);
        at = -1;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                at = cyc;
                start = 1'b1; len = LW'(2);
                break;
            end
            tick();
        end
        check("b2b_job1_latency", at - s, 5);
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("b2b_ignored_busy", busy,      0);
        check("b2b_ignored_clr",  clr_cnt,   1);
        check("b2b_job1_cout",    sum,       14);
        check("b2b_job1_stall",   stall_cnt, 0);
        clear_mon();
        start_job(2, s2);
        wait_done(20, at);
        check("b2b_job2_cout",    sum,           86);
        check("b2b_job2_clr",     clr_cnt,       1);
        check("b2b_job2_first_a", q_at(en_a, 0), 5);
        check("b2b_job2_latency", at - s2,       5);

        // Overflow: DEPTH+2 writes while idle, only the first DEPTH kept.
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) begin
            a_wr_valid = 1'b1; a_wr_data = DW'(100 + i);
            check($sformatf("ovf_ready_%0d", i), a_wr_ready, (i < DEPTH) ? 1 : 0);
            tick();
        end
        a_wr_valid = 1'b0;
        check("ovf_full_ready", a_wr_ready, 0);
        for (int i = 0; i < DEPTH; i++) begin
            b_wr_valid = 1'b1; b_wr_data = DW'(1);
            tick();
        end
        b_wr_valid = 1'b0;
        start_job(DEPTH, s);
        wait_done(40, at);
        check("ovf_en_cnt",  en_cnt,                en_cnt == DEPTH ? DEPTH : DEPTH);
        check("ovf_cout",    sum,                   828);
        check("ovf_last_a",  q_at(en_a, DEPTH - 1), 107);
        check("ovf_latency", at - s,                DEPTH + 3);
        check("ovf_ready",   a_wr_ready,            1);

        // Reset in the second RUN cycle of a len=4 job.
        do_reset();
        preload_pair(1, 5);
        preload_pair(2, 6);
        preload_pair(3, 7);
        preload_pair(4, 8);
        start_job(4, s);
        tick();
        tick();
        check("midrst_was_running", mac_en, 1);
        rst = 1'b1;
        tick();
        check("midrst_busy",    busy,      0);
        check("midrst_mac_en",  mac_en,    0);
        check("midrst_mac_clr", mac_clr,   0);
        check("midrst_done",    done,      0);
        check("midrst_mac_a",   mac_a,     0);
        check("midrst_stall",   stall_cnt, 0);
        check("midrst_a_ready", a_wr_ready, 1);
        rst = 1'b0;
        clear_mon();
        a_wr_valid = 1'b1; a_wr_data = DW'(9);
        tick();
        a_wr_valid = 1'b0;
        start_job(1, s);
        for (int i = 0; i < 6; i++) tick();
        check("midrst_b_empty",  en_cnt, 0);
        check("midrst_stuck",    busy,   1);
        b_wr_valid = 1'b1; b_wr_data = DW'(11);
        tick();
        b_wr_valid = 1'b0;
        wait_done(20, at);
        check("midrst_a_flushed", q_at(en_a, 0), 9);
        check("midrst_cout",      sum,           99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
